// File: rtl/axil_req_frontend_if.sv
// ---------------------------------------------------------------------------
// axil_req_frontend_if
// Bundles the AXI4-Lite slave channels (AW, W, B, AR, R) together with the
// request/completion signals exchanged with the downstream APB transactor.
//   slave  : view of the front end (accepts AXI, issues APB requests)
//   master : view of the surrounding system (AXI master + APB transactor)
// Parameters: dataWidth (32 or 64), addrWidth.
// ---------------------------------------------------------------------------
interface axil_req_frontend_if #(
  parameter int dataWidth = 32,
  parameter int addrWidth = 32
);
  // AXI4-Lite write address / data / response
  logic                   awvalid;
  logic                   awready;
  logic [addrWidth-1:0]   awaddr;
  logic [2:0]             awprot;
  logic                   wvalid;
  logic                   wready;
  logic [dataWidth-1:0]   wdata;
  logic [dataWidth/8-1:0] wstrb;
  logic                   bvalid;
  logic                   bready;
  logic [1:0]             bresp;
  // AXI4-Lite read address / data
  logic                   arvalid;
  logic                   arready;
  logic [addrWidth-1:0]   araddr;
  logic [2:0]             arprot;
  logic                   rvalid;
  logic                   rready;
  logic [dataWidth-1:0]   rdata;
  logic [1:0]             rresp;
  // Request to the APB transactor
  logic                   pselx;
  logic                   pwrite;
  logic [addrWidth-1:0]   paddr;
  logic [dataWidth-1:0]   pwdata;
  logic [dataWidth/8-1:0] pstrb;
  logic [2:0]             pprot;
  // Completion from the APB transactor
  logic                   pready;
  logic [dataWidth-1:0]   prdata;
  logic                   pslverr;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready, pready, prdata, pslverr,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           pselx, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready, pready, prdata, pslverr,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           pselx, pwrite, paddr, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/axil_req_frontend.sv
// ---------------------------------------------------------------------------
// axil_req_frontend
// AXI4-Lite slave front end that serialises write (AW+W) and read (AR)
// transactions into single requests for a downstream APB transactor and
// returns the B / R responses.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - axil_req_frontend_if.slave (AXI channels + APB request/completion)
// Optional feature macro: AXIL_ALIGN_CHECK_EN -- when defined, a request whose
// address is not aligned to the data bus width is answered with SLVERR
// without touching APB. Default build forwards every address unchanged.
// ---------------------------------------------------------------------------
module axil_req_frontend #(
  parameter int dataWidth = 32,
  parameter int addrWidth = 32
) (
  input  logic               clk,
  input  logic               rst,
  axil_req_frontend_if.slave bus
);
  localparam int         StrbW      = dataWidth / 8;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
`ifdef AXIL_ALIGN_CHECK_EN
  localparam int         LsbW       = $clog2(StrbW);
`endif

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP} state_t;

  function automatic logic [1:0] resp_enc(input logic err);
    return err ? RespSlverr : RespOkay;
  endfunction

  state_t                 state_q, state_d;
  logic                   aw_held_q, aw_held_d;
  logic                   w_held_q, w_held_d;
  logic                   ar_held_q, ar_held_d;
  logic                   rr_wr_q, rr_wr_d;  // 1: write wins a contested grant
  logic [addrWidth-1:0]   awaddr_q, awaddr_d;
  logic [2:0]             awprot_q, awprot_d;
  logic [dataWidth-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]       wstrb_q, wstrb_d;
  logic [addrWidth-1:0]   araddr_q, araddr_d;
  logic [2:0]             arprot_q, arprot_d;
  logic                   pselx_q, pselx_d;
  logic                   pwrite_q, pwrite_d;
  logic [addrWidth-1:0]   paddr_q, paddr_d;
  logic [dataWidth-1:0]   pwdata_q, pwdata_d;
  logic [StrbW-1:0]       pstrb_q, pstrb_d;
  logic [2:0]             pprot_q, pprot_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [dataWidth-1:0]   rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;

  logic aw_fire, w_fire, ar_fire;
  logic wr_pend, rd_pend, grant_wr, grant_rd;

  assign aw_fire  = bus.awvalid & ~aw_held_q;
  assign w_fire   = bus.wvalid  & ~w_held_q;
  assign ar_fire  = bus.arvalid & ~ar_held_q;
  assign wr_pend  = aw_held_q & w_held_q;
  assign rd_pend  = ar_held_q;
  assign grant_wr = wr_pend & (~rd_pend | rr_wr_q);
  assign grant_rd = rd_pend & ~grant_wr;

  always_comb begin
    state_d   = state_q;
    // Capture runs in every state; a flag only clears when its transaction
    // completes, and then ready was low that cycle, so set/clear never collide.
    aw_held_d = aw_held_q | aw_fire;
    w_held_d  = w_held_q  | w_fire;
    ar_held_d = ar_held_q | ar_fire;
    rr_wr_d   = rr_wr_q;
    awaddr_d  = aw_fire ? bus.awaddr : awaddr_q;
    awprot_d  = aw_fire ? bus.awprot : awprot_q;
    wdata_d   = w_fire  ? bus.wdata  : wdata_q;
    wstrb_d   = w_fire  ? bus.wstrb  : wstrb_q;
    araddr_d  = ar_fire ? bus.araddr : araddr_q;
    arprot_d  = ar_fire ? bus.arprot : arprot_q;
    pselx_d   = pselx_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (state_q)
      IDLE: begin
        // Priority only flips when both sides actually competed, so a
        // contested pair alternates write-first / read-first.
        if (wr_pend && rd_pend) rr_wr_d = ~rr_wr_q;
        if (grant_wr) begin
`ifdef AXIL_ALIGN_CHECK_EN
          if (|awaddr_q[LsbW-1:0]) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RespSlverr;
            state_d   = WR_RESP;
          end else
`endif
          begin
            pselx_d  = 1'b1;
            pwrite_d = 1'b1;
            paddr_d  = awaddr_q;
            pprot_d  = awprot_q;
            pwdata_d = wdata_q;
            pstrb_d  = wstrb_q;
            state_d  = WR_REQ;
          end
        end else if (grant_rd) begin
`ifdef AXIL_ALIGN_CHECK_EN
          if (|araddr_q[LsbW-1:0]) begin
            ar_held_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = '0;
            rresp_d   = RespSlverr;
            state_d   = RD_RESP;
          end else
`endif
          begin
            pselx_d  = 1'b1;
            pwrite_d = 1'b0;
            paddr_d  = araddr_q;
            pprot_d  = arprot_q;
            pwdata_d = '0;
            pstrb_d  = '0;
            state_d  = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (bus.pready) begin
          pselx_d   = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = resp_enc(bus.pslverr);
          state_d   = WR_RESP;
        end
      end
      RD_REQ: begin
        if (bus.pready) begin
          pselx_d   = 1'b0;
          ar_held_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = bus.prdata;
          rresp_d   = resp_enc(bus.pslverr);
          state_d   = RD_RESP;
        end
      end
      WR_RESP: begin
        if (bus.bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_RESP: begin
        if (bus.rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      rr_wr_q   <= 1'b1;
      pselx_q   <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      ar_held_q <= ar_held_d;
      rr_wr_q   <= rr_wr_d;
      pselx_q   <= pselx_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Captured request payload is qualified by the held flags, so no reset.
  always_ff @(posedge clk) begin
    awaddr_q <= awaddr_d;
    awprot_q <= awprot_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
    araddr_q <= araddr_d;
    arprot_q <= arprot_d;
  end

  assign bus.awready = ~aw_held_q;
  assign bus.wready  = ~w_held_q;
  assign bus.arready = ~ar_held_q;
  assign bus.pselx   = pselx_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.pstrb   = pstrb_q;
  assign bus.pprot   = pprot_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
endmodule

// File: tb/tb_axil_req_frontend.sv
// ---------------------------------------------------------------------------
// tb_axil_req_frontend
// Self-checking bench for axil_req_frontend (32-bit data/address). Drives
// AXI4-Lite transactions, plays the APB transactor, and compares every
// observable against expectations derived from the transaction being sent.
// Honours AXIL_ALIGN_CHECK_EN for the misaligned-address scenario.
// ---------------------------------------------------------------------------
module tb_axil_req_frontend;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  // APB transactor behaviour for the request currently being issued
  int          rsp_wait;
  logic        rsp_err;
  logic [31:0] rsp_data;

  axil_req_frontend_if #(.dataWidth(32), .addrWidth(32)) bus ();

  axil_req_frontend #(.dataWidth(32), .addrWidth(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference rule for B/R response encoding
  function automatic logic [1:0] exp_resp(input logic err);
    return err ? 2'b10 : 2'b00;
  endfunction

  // APB transactor: waits rsp_wait cycles with pselx high, then completes.
  // While idle it toggles pready/prdata/pslverr randomly; these must be ignored.
  initial begin
    int cnt;
    cnt = 0;
    bus.pready  = 1'b0;
    bus.prdata  = '0;
    bus.pslverr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.pselx) begin
        if (cnt >= rsp_wait) begin
          bus.pready  = 1'b1;
          bus.prdata  = rsp_data;
          bus.pslverr = rsp_err;
        end else begin
          bus.pready  = 1'b0;
          bus.prdata  = $urandom;
          bus.pslverr = 1'($urandom_range(0, 1));
          cnt++;
        end
      end else begin
        cnt = 0;
        bus.pready  = 1'($urandom_range(0, 1));
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic send_aw(input logic [31:0] a, input logic [2:0] p, input int dly);
    int n;
    logic r;
    @(negedge clk);
    repeat (dly) @(negedge clk);
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    bus.awprot  = p;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      if (n > 0) @(negedge clk);
      r = bus.awready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.awvalid = 1'b0;
    chk("aw_handshake", 64'(r), 64'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n;
    logic r;
    @(negedge clk);
    repeat (dly) @(negedge clk);
    bus.wvalid = 1'b1;
    bus.wdata  = d;
    bus.wstrb  = s;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      if (n > 0) @(negedge clk);
      r = bus.wready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.wvalid = 1'b0;
    chk("w_handshake", 64'(r), 64'd1);
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [2:0] p, input int dly);
    int n;
    logic r;
    @(negedge clk);
    repeat (dly) @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    bus.arprot  = p;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      if (n > 0) @(negedge clk);
      r = bus.arready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.arvalid = 1'b0;
    chk("ar_handshake", 64'(r), 64'd1);
  endtask

  // Counts idle negedges before pselx is seen; called one step after the
  // capture edge, so the minimum latency shows up as 1.
  task automatic wait_psel(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.pselx) break;
      n++;
    end
    chk("psel_seen", 64'(bus.pselx), 64'd1);
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p, input int bdly);
    int n;
    int cyc;
    wait_psel(n);
    chk("wr_latency", 64'(n), 64'd1);
    cyc = 0;
    while (bus.pselx && cyc < 64) begin
      chk("wr_pwrite", 64'(bus.pwrite), 64'd1);
      chk("wr_paddr", 64'(bus.paddr), 64'(a));
      chk("wr_pwdata", 64'(bus.pwdata), 64'(d));
      chk("wr_pstrb", 64'(bus.pstrb), 64'(s));
      chk("wr_pprot", 64'(bus.pprot), 64'(p));
      chk("wr_bvalid_early", 64'(bus.bvalid), 64'd0);
      cyc++;
      @(negedge clk);
    end
    chk("wr_psel_cycles", 64'(cyc), 64'(rsp_wait + 1));
    chk("wr_bvalid", 64'(bus.bvalid), 64'd1);
    chk("wr_bresp", 64'(bus.bresp), 64'(exp_resp(rsp_err)));
    for (int i = 0; i < bdly; i++) begin
      @(negedge clk);
      chk("wr_bvalid_hold", 64'(bus.bvalid), 64'd1);
      chk("wr_bresp_hold", 64'(bus.bresp), 64'(exp_resp(rsp_err)));
      chk("wr_no_psel", 64'(bus.pselx), 64'd0);
    end
    bus.bready = 1'b1;
    @(posedge clk);
    #1;
    bus.bready = 1'b0;
    chk("wr_bvalid_clear", 64'(bus.bvalid), 64'd0);
  endtask

  task automatic exp_read(input logic [31:0] a, input logic [2:0] p, input int rdly);
    int n;
    int cyc;
    wait_psel(n);
    chk("rd_latency", 64'(n), 64'd1);
    cyc = 0;
    while (bus.pselx && cyc < 64) begin
      chk("rd_pwrite", 64'(bus.pwrite), 64'd0);
      chk("rd_paddr", 64'(bus.paddr), 64'(a));
      chk("rd_pwdata", 64'(bus.pwdata), 64'd0);
      chk("rd_pstrb", 64'(bus.pstrb), 64'd0);
      chk("rd_pprot", 64'(bus.pprot), 64'(p));
      chk("rd_rvalid_early", 64'(bus.rvalid), 64'd0);
      cyc++;
      @(negedge clk);
    end
    chk("rd_psel_cycles", 64'(cyc), 64'(rsp_wait + 1));
    chk("rd_rvalid", 64'(bus.rvalid), 64'd1);
    chk("rd_rdata", 64'(bus.rdata), 64'(rsp_data));
    chk("rd_rresp", 64'(bus.rresp), 64'(exp_resp(rsp_err)));
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("rd_rvalid_hold", 64'(bus.rvalid), 64'd1);
      chk("rd_rdata_hold", 64'(bus.rdata), 64'(rsp_data));
      chk("rd_no_psel", 64'(bus.pselx), 64'd0);
    end
    bus.rready = 1'b1;
    @(posedge clk);
    #1;
    bus.rready = 1'b0;
    chk("rd_rvalid_clear", 64'(bus.rvalid), 64'd0);
  endtask

  initial begin
    int          n;
    logic        is_wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
    int          d0, d1, d2;

    n_vec = 0;
    n_err = 0;
    rsp_wait = 0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
    bus.bready  = 1'b0; bus.rready = 1'b0;
    rst = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pselx", 64'(bus.pselx), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_pstrb", 64'(bus.pstrb), 64'd0);
    chk("rst_awready", 64'(bus.awready), 64'd1);
    chk("rst_wready", 64'(bus.wready), 64'd1);
    chk("rst_arready", 64'(bus.arready), 64'd1);
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Write 0x10 <- DEADBEEF, two APB wait cycles
    rsp_wait = 2; rsp_err = 1'b0; rsp_data = 32'h0;
    fork
      send_aw(32'h10, 3'd0, 0);
      send_w(32'hDEAD_BEEF, 4'hF, 0);
    join
    exp_write(32'h10, 32'hDEAD_BEEF, 4'hF, 3'd0, 0);

    // Read 0x20 with slave error
    rsp_wait = 1; rsp_err = 1'b1; rsp_data = 32'h1234_5678;
    send_ar(32'h20, 3'd2, 0);
    exp_read(32'h20, 3'd2, 2);

    // W three cycles ahead of AW
    rsp_wait = 0; rsp_err = 1'b0;
    send_w(32'hA5A5_0F0F, 4'h6, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wfirst_wready", 64'(bus.wready), 64'd0);
      chk("wfirst_no_psel", 64'(bus.pselx), 64'd0);
    end
    send_aw(32'h84, 3'd5, 0);
    exp_write(32'h84, 32'hA5A5_0F0F, 4'h6, 3'd5, 0);
    repeat (3) begin
      @(negedge clk);
      chk("wfirst_single", 64'(bus.pselx), 64'd0);
    end

    // bready held low 5 cycles while a read waits
    rsp_wait = 0; rsp_err = 1'b1; rsp_data = 32'hCAFE_0001;
    fork
      send_aw(32'h30, 3'd1, 0);
      send_w(32'h0000_1111, 4'h3, 0);
    join
    fork
      exp_write(32'h30, 32'h0000_1111, 4'h3, 3'd1, 5);
      send_ar(32'h34, 3'd0, 0);
    join
    rsp_err = 1'b0;
    exp_read(32'h34, 3'd0, 0);

    // Reset pulse while a write request is on APB
    rsp_wait = 10;
    fork
      send_aw(32'h50, 3'd0, 0);
      send_w(32'h5555_5555, 4'hF, 0);
    join
    wait_psel(n);
    rst = 1'b0;
    #1;
    chk("abort_pselx", 64'(bus.pselx), 64'd0);
    chk("abort_bvalid", 64'(bus.bvalid), 64'd0);
    chk("abort_awready", 64'(bus.awready), 64'd1);
    chk("abort_wready", 64'(bus.wready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_bvalid", 64'(bus.bvalid), 64'd0);
      chk("abort_no_psel", 64'(bus.pselx), 64'd0);
    end

    // Write and read contending: write first after reset, then read first
    rsp_wait = 0; rsp_err = 1'b0; rsp_data = 32'h0BAD_F00D;
    fork
      send_aw(32'h40, 3'd0, 0);
      send_w(32'h1357_9BDF, 4'hF, 0);
      send_ar(32'h44, 3'd0, 0);
    join
    exp_write(32'h40, 32'h1357_9BDF, 4'hF, 3'd0, 0);
    exp_read(32'h44, 3'd0, 0);
    fork
      send_aw(32'h48, 3'd0, 0);
      send_w(32'h2468_ACE0, 4'hF, 0);
      send_ar(32'h4C, 3'd0, 0);
    join
    exp_read(32'h4C, 3'd0, 0);
    exp_write(32'h48, 32'h2468_ACE0, 4'hF, 3'd0, 0);

    // Misaligned read address
    rsp_wait = 0; rsp_err = 1'b0; rsp_data = 32'h7777_7777;
    send_ar(32'h22, 3'd0, 0);
`ifdef AXIL_ALIGN_CHECK_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("align_no_psel", 64'(bus.pselx), 64'd0);
      if (bus.rvalid) break;
    end
    chk("align_rvalid", 64'(bus.rvalid), 64'd1);
    chk("align_rresp", 64'(bus.rresp), 64'd2);
    chk("align_rdata", 64'(bus.rdata), 64'd0);
    bus.rready = 1'b1;
    @(posedge clk);
    #1;
    bus.rready = 1'b0;
    chk("align_rvalid_clear", 64'(bus.rvalid), 64'd0);
`else
    exp_read(32'h22, 3'd0, 0);
`endif

    // Randomised single transactions
    for (int t = 0; t < 40; t++) begin
      is_wr    = 1'($urandom_range(0, 1));
      a        = $urandom & 32'h0000_FFFC;
      d        = $urandom;
      s        = 4'($urandom_range(0, 15));
      p        = 3'($urandom_range(0, 7));
      d0       = $urandom_range(0, 3);
      d1       = $urandom_range(0, 3);
      d2       = $urandom_range(0, 3);
      rsp_wait = $urandom_range(0, 3);
      rsp_err  = 1'($urandom_range(0, 1));
      rsp_data = $urandom;
      if (is_wr) begin
        fork
          send_aw(a, p, d0);
          send_w(d, s, d1);
        join
        exp_write(a, d, s, p, d2);
      end else begin
        send_ar(a, p, d0);
        exp_read(a, p, d2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
